spi_frame_buffer: RTL

- Host-side buffering and framing stage directly upstream of the SPI_cont byte controller.
- Accepts bytes from the host into a TX FIFO and feeds them one at a time to SPI_cont over W_STB/W_DATA, respecting W_READY.
- Captures each received byte (R_STB/R_DATA) into an RX FIFO.
- Drives chip select CS_N around each burst, with setup and hold times counted in TICK pulses from the shared divider.

---
 rtl/spi_pkg.sv | 18 +
 rtl/sync_fifo.sv | 46 ++++
 rtl/spi_frame_buffer.sv | 122 ++++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI frame buffer: frame FSM encoding and byte width.
package spi_pkg;

    localparam int SPI_BYTE_W = 8;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETUP   = 3'd1,
        LAUNCH  = 3'd2,
        WAIT_RX = 3'd3,
        HOLD    = 3'd4
    } fsm_state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with first-word-fall-through head; head reads 0 while empty.
// A push into a full FIFO succeeds only when a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int AW    = 3
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int DEPTH = 1 << AW;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr;
    logic [AW:0]      rptr;
    logic             do_push;
    logic             do_pop;

    // Extra pointer MSB tells a full FIFO apart from an empty one.
    assign empty   = (wptr == rptr);
    assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = empty ? '0 : mem[rptr[AW-1:0]];

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (do_push) mem[wptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/spi_frame_buffer.sv
// Host-side TX/RX byte buffering and chip-select framing in front of the SPI byte controller.
// Chip select brackets each burst with setup/hold times counted in shared-divider TICKs.
module spi_frame_buffer
    import spi_pkg::*;
#(
    parameter int FIFO_AW        = 3,
    parameter int CS_SETUP_TICKS = 2,
    parameter int CS_HOLD_TICKS  = 2
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  TICK,
    input  logic                  TX_WR,
    input  logic [SPI_BYTE_W-1:0] TX_DATA,
    output logic                  TX_FULL,
    input  logic                  RX_RD,
    output logic [SPI_BYTE_W-1:0] RX_DATA,
    output logic                  RX_EMPTY,
    output logic                  RX_OVF,
    input  logic                  RX_OVF_CLR,
    output logic                  BUSY,
    output logic                  CS_N,
    output logic                  W_STB,
    output logic [SPI_BYTE_W-1:0] W_DATA,
    input  logic                  W_READY,
    input  logic                  R_STB,
    input  logic [SPI_BYTE_W-1:0] R_DATA
);

    localparam int MAX_TICKS = max_int(CS_SETUP_TICKS, CS_HOLD_TICKS);
    localparam int CNT_W     = (MAX_TICKS < 1) ? 1 : $clog2(MAX_TICKS + 1);

    fsm_state_t             state;
    fsm_state_t             state_nxt;
    logic [CNT_W-1:0]       tick_cnt;
    logic                   tx_empty;
    logic                   tx_pop;
    logic [SPI_BYTE_W-1:0]  tx_head;
    logic                   rx_full;
    logic                   rx_drop;
    logic                   setup_done;
    logic                   hold_done;

    sync_fifo #(.WIDTH(SPI_BYTE_W), .AW(FIFO_AW)) u_tx_fifo (
        .CLK   (CLK),
        .RST   (RST),
        .push  (TX_WR),
        .pop   (tx_pop),
        .wdata (TX_DATA),
        .rdata (tx_head),
        .full  (TX_FULL),
        .empty (tx_empty)
    );

    sync_fifo #(.WIDTH(SPI_BYTE_W), .AW(FIFO_AW)) u_rx_fifo (
        .CLK   (CLK),
        .RST   (RST),
        .push  (R_STB),
        .pop   (RX_RD),
        .wdata (R_DATA),
        .rdata (RX_DATA),
        .full  (rx_full),
        .empty (RX_EMPTY)
    );

    assign rx_drop    = R_STB && rx_full && !RX_RD;
    assign setup_done = TICK && (int'(tick_cnt) == CS_SETUP_TICKS - 1);
    assign hold_done  = TICK && (int'(tick_cnt) == CS_HOLD_TICKS - 1);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (!tx_empty) state_nxt = (CS_SETUP_TICKS == 0) ? LAUNCH : SETUP;
            SETUP:   if (setup_done) state_nxt = LAUNCH;
            LAUNCH:  if (W_READY) state_nxt = WAIT_RX;
            WAIT_RX: begin
                if (R_STB) begin
                    if (!tx_empty)               state_nxt = LAUNCH;
                    else if (CS_HOLD_TICKS == 0) state_nxt = IDLE;
                    else                         state_nxt = HOLD;
                end
            end
            HOLD:    if (hold_done) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Launch handshake: a byte leaves only when W_READY is high in LAUNCH; W_STB is the
    // registered one-cycle echo of that pop, and the next launch waits for R_STB.
    always_comb begin
        tx_pop = 1'b0;
        BUSY   = (state != IDLE);
        if (state == LAUNCH) tx_pop = W_READY;
    end

    // CS_N is registered from the next state so it changes on the transition edge glitch-free.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            tick_cnt <= '0;
            CS_N     <= 1'b1;
            W_STB    <= 1'b0;
            W_DATA   <= '0;
            RX_OVF   <= 1'b0;
        end else begin
            if (state_nxt != state)
                tick_cnt <= '0;
            else if (TICK && (state == SETUP || state == HOLD))
                tick_cnt <= tick_cnt + 1'b1;
            CS_N  <= (state_nxt == IDLE);
            W_STB <= tx_pop;
            if (tx_pop) W_DATA <= tx_head;
            if (rx_drop)         RX_OVF <= 1'b1;
            else if (RX_OVF_CLR) RX_OVF <= 1'b0;
        end
    end

endmodule
